// File: rtl/magic_freq_counter.sv
// magic_freq_counter
// Readout stage behind the analog macro of tt_um_magic_challenge. The
// macro output is synchronised into clk, and its rising edges are counted
// over a gate window of GATE_CYCLES clocks. The result and status are
// presented one byte at a time on dout. The measured frequency is
// count * f_clk / GATE_CYCLES.
//
// Parameters
//   GATE_CYCLES  gate window length in clk cycles (2..65535)
//   CNT_W        edge-count width (9..16); the count saturates at 2^CNT_W-1
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ena       tile enable; low aborts and returns the block to IDLE
//   meas_in   asynchronous signal from the analog macro
//   start     single-cycle measurement request (accepted in IDLE/DONE)
//   byte_sel  dout select: 0 count[7:0], 1 count[CNT_W-1:8],
//             2 {5'b0, ovf, busy, done}, 3 ID byte 8'hA5
//   busy      measurement in progress (ARM or GATE)
//   done      result valid (DONE)
//   dout      selected byte
//
// Build option
//   MAGIC_FC_CONTINUOUS_EN  when defined, DONE re-arms automatically on the
//   next cycle, so done pulses once per window. The result is latched into
//   a shadow register on DONE entry, and dout bytes 0-2 read that shadow.
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for start with ena high
//   ARM    | one cycle: clear count, ovf and gate counter
//   GATE   | GATE_CYCLES cycles of edge counting
//   DONE   | result valid; held (or re-armed in continuous mode)

module magic_freq_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       meas_in,
    input  logic       start,
    input  logic [1:0] byte_sel,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout
);

    // One extra value of headroom lets the gate counter step past the last
    // gate cycle without wrapping.
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [7:0]       ID_BYTE   = 8'hA5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_GATE = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state;
    logic              s1, s2, s3;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              ovf;
    logic              ovf_nxt;
    logic [GW-1:0]     gate_cnt;
    logic              gate_last;
    logic [CNT_W-1:0]  rd_cnt;
    logic              rd_ovf;
    logic [15:0]       rd_cnt16;

    // s1/s2 are the synchroniser; s3 only delays s2 for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= meas_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Saturating edge count; edges arriving at full scale set the sticky ovf.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (state == S_GATE && rise) begin
            if (cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign gate_last = (state == S_GATE) && (gate_cnt == GATE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ovf      <= 1'b0;
            gate_cnt <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (!ena) begin
            // Abort wins over everything, including a coincident start.
            // Count and ovf are left as they are.
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                    end
                end
                S_ARM: begin
                    cnt      <= '0;
                    ovf      <= 1'b0;
                    gate_cnt <= '0;
                    state    <= S_GATE;
                end
                S_GATE: begin
                    cnt      <= cnt_nxt;
                    ovf      <= ovf_nxt;
                    gate_cnt <= gate_cnt + 1'b1;
                    if (gate_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
`ifdef MAGIC_FC_CONTINUOUS_EN
                    state <= S_ARM;
                    busy  <= 1'b1;
                    done  <= 1'b0;
`else
                    if (start) begin
                        state <= S_ARM;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MAGIC_FC_CONTINUOUS_EN
    logic [CNT_W-1:0] shadow_cnt;
    logic             shadow_ovf;

    // Capture the final value (including an edge in the last gate cycle)
    // on the same edge that enters DONE, before ARM clears the live count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_cnt <= '0;
            shadow_ovf <= 1'b0;
        end else if (ena && gate_last) begin
            shadow_cnt <= cnt_nxt;
            shadow_ovf <= ovf_nxt;
        end
    end

    assign rd_cnt = shadow_cnt;
    assign rd_ovf = shadow_ovf;
`else
    assign rd_cnt = cnt;
    assign rd_ovf = ovf;
`endif

    assign rd_cnt16 = 16'(rd_cnt);

    always_comb begin
        dout = ID_BYTE;
        unique case (byte_sel)
            2'd0:    dout = rd_cnt16[7:0];
            2'd1:    dout = rd_cnt16[15:8];
            2'd2:    dout = {5'b0, rd_ovf, busy, done};
            default: dout = ID_BYTE;
        endcase
    end

endmodule

// File: tb/tb_magic_freq_counter.sv
module tb_magic_freq_counter;

`ifdef MAGIC_FC_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    localparam int G_A = 100;
    localparam int W_A = 16;
    localparam int G_B = 2000;
    localparam int W_B = 9;
    localparam int NSAMP = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       meas_in = 1'b0;
    logic       start = 1'b0;
    logic [1:0] byte_sel = 2'd0;
    logic       use_b = 1'b0;

    logic       start_a, start_b;
    logic       busy_a, done_a, busy_b, done_b;
    logic [7:0] dout_a, dout_b;
    logic       busy_s, done_s;
    logic [7:0] dout_s;

    int errors = 0;
    int checks = 0;

    // meas_in value seen at each clk edge, indexed by edge number
    bit samp [0:NSAMP-1];
    int cyc = 0;

    int wmode = 0;   // 0: square wave, 1: random bits
    int wper  = 10;
    int ph    = 0;

    assign start_a = start && !use_b;
    assign start_b = start && use_b;
    assign busy_s  = use_b ? busy_b : busy_a;
    assign done_s  = use_b ? done_b : done_a;
    assign dout_s  = use_b ? dout_b : dout_a;

    magic_freq_counter #(.GATE_CYCLES(G_A), .CNT_W(W_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena), .meas_in(meas_in),
        .start(start_a), .byte_sel(byte_sel),
        .busy(busy_a), .done(done_a), .dout(dout_a)
    );

    magic_freq_counter #(.GATE_CYCLES(G_B), .CNT_W(W_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .ena(ena), .meas_in(meas_in),
        .start(start_b), .byte_sel(byte_sel),
        .busy(busy_b), .done(done_b), .dout(dout_b)
    );

    always #5 clk = ~clk;

    // Record each edge's sample, then drive the next meas_in value.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc < NSAMP) samp[cyc] = meas_in;
        #1;
        if (wmode == 0) begin
            ph = (ph + 1) % wper;
            meas_in = (ph < wper / 2);
        end else begin
            meas_in = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_byte(input logic [1:0] sel, output int val);
        byte_sel = sel;
        #1;
        val = int'(dout_s);
    endtask

    // Reference: a window whose ARM state follows edge n counts the rising
    // transitions among the samples taken at edges n .. n+g-1, saturated.
    task automatic model_count(input int n, input int g, input int w,
                               output int cnt, output bit ovf);
        int r = 0;
        int mx = (1 << w) - 1;
        for (int j = n; j < n + g; j++)
            if (samp[j] && !samp[j-1]) r++;
        ovf = (r > mx);
        cnt = ovf ? mx : r;
    endtask

    task automatic check_result(input string tag, input int n, input int g,
                                input int w, output int ecnt);
        bit eovf;
        int v;
        model_count(n, g, w, ecnt, eovf);
        read_byte(2'd0, v); check({tag, "_lo"}, v, ecnt & 255);
        read_byte(2'd1, v); check({tag, "_hi"}, v, (ecnt >> 8) & 255);
        read_byte(2'd2, v); check({tag, "_status"}, v, {29'd0, eovf, 1'b0, 1'b1});
    endtask

    // Start a measurement on the selected instance. pulse_at >= 0 issues an
    // extra start during GATE; abort_at >= 0 drops ena at that point.
    task automatic run_meas(input int g, input int w, input int pulse_at,
                            input int abort_at, output int ecnt);
        int n, d, v;
        bit seen;
        ecnt = -1;
        start = 1'b1;
        n = cyc + 1;
        step();
        start = 1'b0;
        check("busy_arm", busy_s, 1);
        seen = 1'b0;
        for (int k = 1; k < g + 20; k++) begin
            if (k == pulse_at) start = 1'b1;
            if (k == pulse_at + 1) start = 1'b0;
            step();
            if (k == abort_at) begin
                ena = 1'b0;
                step();
                check("abort_busy", busy_s, 0);
                check("abort_done", done_s, 0);
                read_byte(2'd2, v);
                check("abort_status", v, 0);
                ena = 1'b1;
                return;
            end
            if (done_s) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", seen, 1);
        if (!seen) return;
        d = cyc;
        check("done_latency", d - n, g + 1);
        check("done_busy", busy_s, 0);
        check_result("win", n, g, w, ecnt);
        if (CONT) begin
            int c2;
            step();
            check("cont_pulse_done", done_s, 0);
            check("cont_rearm_busy", busy_s, 1);
            seen = 1'b0;
            for (int k = 0; k < g + 20; k++) begin
                step();
                if (done_s) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("cont_done_seen", seen, 1);
            if (seen) begin
                check("cont_period", cyc - d, g + 2);
                check_result("cont_win", d + 1, g, w, c2);
            end
            ena = 1'b0;
            step();
            ena = 1'b1;
        end else begin
            repeat (5) step();
            check("done_hold", done_s, 1);
            read_byte(2'd0, v);
            check("hold_lo", v, ecnt & 255);
        end
    endtask

    initial begin
        int v, ec;

        // Reset values
        #3;
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        for (int s = 0; s < 3; s++) begin
            read_byte(2'(s), v);
            check("rst_byte", v, 0);
        end
        read_byte(2'd3, v);
        check("rst_id", v, 8'hA5);
        use_b = 1'b1;
        read_byte(2'd3, v);
        check("rst_id_b", v, 8'hA5);
        use_b = 1'b0;

        step();
        rst_n = 1'b1;
        ena   = 1'b1;
        wmode = 0; wper = 10; ph = 0;
        repeat (15) step();

        // start with ena low is ignored
        ena = 1'b0; start = 1'b1;
        step();
        start = 1'b0; ena = 1'b1;
        check("start_no_ena", busy_a, 0);

        // Nominal period-10 window
        run_meas(G_A, W_A, -1, -1, ec);
        check("nom_model10", ec, 10);
        if (!CONT) begin
            read_byte(2'd0, v);
            check("nom_cnt", v, 10);
            read_byte(2'd2, v);
            check("nom_status", v, 8'h01);
        end

        // Randomised inputs
        for (int it = 0; it < 6; it++) begin
            wmode = int'($urandom_range(0, 1));
            wper  = int'($urandom_range(2, 20));
            ph    = int'($urandom_range(0, wper - 1));
            repeat ($urandom_range(3, 15)) step();
            run_meas(G_A, W_A, -1, -1, ec);
        end

        // start during GATE has no effect on the window
        wmode = 0; wper = 10; ph = 3;
        repeat (5) step();
        run_meas(G_A, W_A, 30, -1, ec);
        check("ign_cnt10", ec, 10);

        // Abort at gate cycle 50, then a fresh measurement
        run_meas(G_A, W_A, -1, 50, ec);
        repeat (3) step();
        run_meas(G_A, W_A, -1, -1, ec);
        check("after_abort10", ec, 10);

        // start coinciding with ena fall: ena wins
        ena = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        check("ena_wins_busy", busy_a, 0);
        check("ena_wins_done", done_a, 0);
        ena = 1'b1;
        step();

        // Overflow: 9-bit count, 2000-cycle gate, period-2 input
        wmode = 0; wper = 2; ph = 0;
        use_b = 1'b1;
        repeat (4) step();
        run_meas(G_B, W_B, -1, -1, ec);
        check("ovf_model", ec, 511);
        if (!CONT) begin
            read_byte(2'd1, v);
            check("ovf_hi", v, 8'h01);
            read_byte(2'd2, v);
            check("ovf_status", v, 8'h05);
        end
        use_b = 1'b0;

        // Reset during GATE
        wper = 10;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("pre_rst_busy", busy_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_a, 0);
        check("mid_rst_done", done_a, 0);
        read_byte(2'd0, v);
        check("mid_rst_lo", v, 0);
        read_byte(2'd3, v);
        check("mid_rst_id", v, 8'hA5);
        use_b = 1'b1;
        read_byte(2'd0, v);
        check("mid_rst_lo_b", v, 0);
        read_byte(2'd2, v);
        check("mid_rst_status_b", v, 0);
        use_b = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        check("post_rst_busy", busy_a, 0);
        run_meas(G_A, W_A, -1, -1, ec);
        check("post_rst10", ec, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
